// File: rtl/fd_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// Optional feature macro: FD_EXC_EN (per-entry exception code, d_exc port).
package fd_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Instruction-memory window; fetches outside it raise AdEL.
  localparam logic [31:0] IM_LO = 32'h0000_3000;
  localparam logic [31:0] IM_HI = 32'h0000_6FFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
`ifdef FD_EXC_EN
    logic [4:0]  excode;
`endif
  } fd_entry_t;

  // Misaligned or out-of-window fetch address.
  function automatic logic [4:0] fd_excode(input logic [31:0] pc);
    if (pc[1:0] != 2'b00 || pc < IM_LO || pc > IM_HI) return EXC_ADEL;
    return EXC_NONE;
  endfunction

endpackage

// File: rtl/fd_instr_queue_if.sv
// Fetch/decode handshake bundle for fd_instr_queue.
// Optional feature macro: FD_EXC_EN adds d_exc.
interface fd_instr_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [31:0]    f_pc;
  logic [31:0]    f_instr;
  logic           f_valid;
  logic           f_en;
  logic           flush;
  logic           d_ready;
  logic           d_valid;
  logic [31:0]    d_pc;
  logic [31:0]    d_instr;
  logic [PTR_W:0] count;
`ifdef FD_EXC_EN
  logic [4:0]     d_exc;
`endif

  // Environment side: fetch unit, branch resolution and decode.
  modport master (
    output f_pc, f_instr, f_valid, flush, d_ready,
`ifdef FD_EXC_EN
    input  d_exc,
`endif
    input  f_en, d_valid, d_pc, d_instr, count
  );

  // Queue side.
  modport slave (
    input  f_pc, f_instr, f_valid, flush, d_ready,
`ifdef FD_EXC_EN
    output d_exc,
`endif
    output f_en, d_valid, d_pc, d_instr, count
  );

endinterface

// File: rtl/fd_queue_ram.sv
// DEPTH-entry register file: synchronous write, combinational read.
// Optional feature macro: FD_EXC_EN widens the stored entry.
module fd_queue_ram
  import fd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  fd_entry_t        wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output fd_entry_t        rdata_o
);

  fd_entry_t mem_q [DEPTH];

  // Write port; contents are not reset, pointers alone define validity.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Combinational read of the addressed entry.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/fd_instr_queue.sv
// Fetch-to-decode instruction queue: buffers {PC, instr} pairs, back-pressures
// fetch through f_en and drops everything on a redirect flush.
// Optional feature macro: FD_EXC_EN tags each entry with an AdEL exception code.
module fd_instr_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = $clog2(DEPTH),
  parameter logic [31:0] RESET_PC = fd_pkg::RESET_PC
) (
  input logic            clk,
  input logic            reset,
  fd_instr_queue_if.slave bus
);
  import fd_pkg::*;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             f_en, d_valid, push, pop;
  fd_entry_t        wr_entry, rd_entry;

  // Handshake decode; f_en depends only on registered count.
  always_comb begin
    f_en    = (count_q != FULL_CNT);
    d_valid = (count_q != '0);
    push    = bus.f_valid & f_en & ~bus.flush;
    pop     = d_valid & bus.d_ready & ~bus.flush;
  end

  // Build the entry to store for this cycle's fetch.
  always_comb begin
    wr_entry.pc    = bus.f_pc;
    wr_entry.instr = bus.f_instr;
`ifdef FD_EXC_EN
    wr_entry.excode = fd_excode(bus.f_pc);
    if (wr_entry.excode == EXC_ADEL) wr_entry.instr = 32'h0;
`endif
  end

  fd_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // Pointer and occupancy next state; flush wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: natural overflow is the modulo wrap.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Outputs; an empty queue presents RESET_PC and a nop.
  always_comb begin
    bus.f_en    = f_en;
    bus.d_valid = d_valid;
    bus.count   = count_q;
    bus.d_pc    = d_valid ? rd_entry.pc    : RESET_PC;
    bus.d_instr = d_valid ? rd_entry.instr : 32'h0;
`ifdef FD_EXC_EN
    bus.d_exc   = d_valid ? rd_entry.excode : EXC_NONE;
`endif
  end

  a_count_max: assert property (@(posedge clk) disable iff (reset) count_q <= FULL_CNT);
  a_count_min: assert property (@(posedge clk) disable iff (reset) pop |-> count_q != '0);

endmodule
